// File: rtl/rst_req_gen.sv
// Reset-request source: turns a raw pushbutton or a one-cycle soft request into one clean, stretched rst_req pulse.
// Hold-off and button-release wait after each pulse guarantee exactly one pulse per press; requests arriving while busy are dropped.
module rst_req_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 8,
    parameter int HOLDOFF_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       sw_req,
    output logic       rst_req,
    output logic       busy,
    output logic [7:0] req_count
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
    localparam int MAX_P = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    // The IDLE cycle that first sees btn_s already counts as debounce cycle 1.
    localparam logic [CW-1:0] DB_LAST    = CW'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ASSERT   = 2'd2,
        HOLDOFF  = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rst_req_q;
    logic                   busy_q;
    logic [7:0]             req_count_q;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sw_req) begin
                    state_d = ASSERT;
                end else if (btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ASSERT;
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (sw_req) begin
                    state_d = ASSERT;
                end else if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ASSERT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLDOFF: begin
                // Counter parks at its last value while a held button keeps us here.
                if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!btn_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rst_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_count_q <= 8'd0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_req_q <= (state_q == ASSERT);
            busy_q    <= (state_q != IDLE);
            if ((state_d == ASSERT) && (state_q != ASSERT) && (req_count_q != 8'hFF)) begin
                req_count_q <= req_count_q + 8'd1;
            end
        end
    end

    assign rst_req   = rst_req_q;
    assign busy      = busy_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: phase-countdown reference model checked every cycle, plus directed literal checks.
module tb_rst_req_gen;

    localparam int SYNC = 2;
    localparam int DB   = 16;
    localparam int P    = 8;
    localparam int H    = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic       sw_req = 1'b0;
    logic       rst_req;
    logic       busy;
    logic [7:0] req_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_req_gen #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES(P),
        .HOLDOFF_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .sw_req(sw_req),
        .rst_req(rst_req),
        .busy(busy),
        .req_count(req_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: remaining-cycle countdowns per phase; outputs lag the phase by one edge.
    bit m_sh [SYNC];
    bit m_bs = 1'b0;
    int m_run = 0;
    int m_pulse = 0;
    int m_hold = 0;
    int m_cnt = 0;
    bit e_rst_req = 1'b0;
    bit e_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
            m_run = 0; m_pulse = 0; m_hold = 0; m_cnt = 0;
            e_rst_req = 1'b0; e_busy = 1'b0;
        end else begin
            m_bs      = m_sh[SYNC-1];
            e_rst_req = (m_pulse > 0);
            e_busy    = (m_pulse > 0) || (m_hold > 0) || (m_run > 0);
            if (m_pulse > 0) begin
                if (m_pulse > 1) m_pulse--;
                else begin m_pulse = 0; m_hold = H; end
            end else if (m_hold > 0) begin
                if (m_hold > 1) m_hold--;
                else if (!m_bs) m_hold = 0;
            end else if (sw_req || (m_bs && m_run + 1 >= DB)) begin
                m_run = 0;
                m_pulse = P;
                if (m_cnt < 255) m_cnt++;
            end else if (m_bs) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = btn_raw;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_rst_req", rst_req, e_rst_req);
            chk("model_busy", busy, e_busy);
            chk("model_req_count", req_count, m_cnt);
        end
    end

    int  pulses = 0;
    logic prev_r = 1'b0;
    always @(negedge clk) begin
        if (rst_req === 1'b1 && prev_r !== 1'b1) pulses++;
        prev_r = rst_req;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sw_req = 1'b0; btn_raw = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rise_k;
        repeat (3) @(negedge clk);
        chk("reset_rst_req", rst_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_count", req_count, 0);
        rst = 1'b0;

        // Soft request: sampled at edge N, pulse after N+1..N+8, idle after N+41
        do_reset();
        @(negedge clk); sw_req = 1'b1;
        @(negedge clk); sw_req = 1'b0;
        chk("sw_k0_rst_req", rst_req, 0);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1)  chk("sw_k1_rst_req", rst_req, 1);
            if (k == 8)  chk("sw_k8_rst_req", rst_req, 1);
            if (k == 9)  chk("sw_k9_rst_req", rst_req, 0);
            if (k == 40) chk("sw_k40_busy", busy, 1);
            if (k == 41) chk("sw_k41_busy", busy, 0);
        end
        chk("sw_req_count", req_count, 1);

        // Held button: rise 18 edges after first sample, one pulse only
        do_reset();
        pulses = 0;
        rise_k = -1;
        @(negedge clk); btn_raw = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rise_k < 0 && rst_req === 1'b1) rise_k = k;
        end
        chk("btn_rise_edge", rise_k, 18);
        chk("btn_held_busy", busy, 1);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("btn_pulses", pulses, 1);
        chk("btn_release_busy", busy, 0);
        chk("btn_req_count", req_count, 1);

        // Glitch shorter than the debounce window
        do_reset();
        pulses = 0;
        @(negedge clk); btn_raw = 1'b1;
        repeat (10) @(negedge clk);
        btn_raw = 1'b0;
        repeat (40) @(negedge clk);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_req_count", req_count, 0);
        chk("glitch_busy", busy, 0);

        // sw_req during debounce cycle 5 wins; sw_req in hold-off is dropped
        do_reset();
        pulses = 0;
        @(negedge clk); btn_raw = 1'b1;
        repeat (6) @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk); sw_req = 1'b0; btn_raw = 1'b0;
        chk("prio_before_rst_req", rst_req, 0);
        @(negedge clk);
        chk("prio_rst_req", rst_req, 1);
        repeat (15) @(negedge clk);
        sw_req = 1'b1;
        @(negedge clk); sw_req = 1'b0;
        repeat (60) @(negedge clk);
        chk("drop_pulses", pulses, 1);
        chk("drop_req_count", req_count, 1);
        chk("drop_busy", busy, 0);

        // Asynchronous reset mid-pulse
        do_reset();
        @(negedge clk); sw_req = 1'b1;
        @(negedge clk); sw_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_req_high", rst_req, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", rst_req, 0);
        chk("async_busy", busy, 0);
        chk("async_req_count", req_count, 0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_busy", busy, 0);

        // Randomized mix against the model
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) btn_raw = ~btn_raw;
            sw_req = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk); sw_req = 1'b0; btn_raw = 1'b0;
        repeat (60) @(negedge clk);

        // Saturation
        do_reset();
        pulses = 0;
        for (int r = 0; r < 260; r++) begin
            @(negedge clk); sw_req = 1'b1;
            @(negedge clk); sw_req = 1'b0;
            repeat (48) @(negedge clk);
        end
        chk("sat_pulses", pulses, 260);
        chk("sat_req_count", req_count, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_req_gen.md
Name: rst_req_gen

Overview:
- Reset-request source for the game fabric: the asserting end of the on-chip reset path, opposite the power-up reset releaser.
- Takes a raw board pushbutton and a synchronous soft-restart request from game logic, and issues one clean, stretched, active-high reset pulse.
- Downstream blocks (paddle, ball, score) consume `rst_req` as a synchronous restart.
- A hold-off period and a button-release wait guarantee one pulse per press.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `btn_raw` (≥2).
- DEBOUNCE_CYCLES, 16, consecutive synchronized-high cycles required to accept a press (≥1).
- PULSE_CYCLES, 8, width of the `rst_req` pulse in clk cycles (≥1).
- HOLDOFF_CYCLES, 32, minimum idle cycles after the pulse before a new request is accepted (≥1).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw pushbutton, active-high, asynchronous to clk.
- sw_req  input  1  one-cycle synchronous restart request from game logic.
- rst_req  output  1  registered active-high reset pulse to downstream modules.
- busy  output  1  high in every state except IDLE.
- req_count  output  8  saturating count of issued pulses.

Behaviour:
- Reset:
  - clk and a single asynchronous, active-high reset `rst`. Reset is applied immediately on assertion, independent of clk.
  - While `rst`=1: all synchronizer flops 0, state IDLE, all counters 0, `rst_req`=0, `busy`=0, `req_count`=0.
  - Reset asserted mid-operation aborts any pulse at once, and `rst_req` drops asynchronously.
- Synchronizer: `btn_raw` passes through SYNC_STAGES flops to produce `btn_s`. `btn_raw` is never used directly in logic.
- Counters: cycle counters are sized $clog2(max parameter + 1). They are cleared on every state entry.
- FSM states: IDLE, DEBOUNCE, ASSERT, HOLDOFF.
- IDLE:
  - `sw_req`=1 → ASSERT (takes priority over the button).
  - Else `btn_s`=1 → DEBOUNCE. The cycle that sees `btn_s`=1 counts as debounce cycle 1.
- DEBOUNCE:
  - `btn_s`=0 on any cycle → IDLE (glitch rejected, no pulse, count unchanged).
  - `sw_req`=1 → ASSERT immediately, abandoning the debounce.
  - DEBOUNCE_CYCLES consecutive `btn_s`=1 cycles → ASSERT.
- ASSERT:
  - `rst_req`=1 for exactly PULSE_CYCLES cycles, then HOLDOFF.
  - `req_count` increments once on ASSERT entry and saturates at 255.
- HOLDOFF:
  - `rst_req`=0. Stay at least HOLDOFF_CYCLES cycles.
  - Then wait until `btn_s`=0, then → IDLE.
  - A held button therefore never retriggers.
- Dropped requests: `sw_req` and button activity during ASSERT or HOLDOFF are dropped, not queued.
- Latency:
  - `sw_req` sampled 1 at edge N → `rst_req`=1 after edge N+1.
  - `btn_raw` first sampled 1 at edge t0 and held → `rst_req`=1 after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults).
- Outputs: `rst_req` is a registered output with no combinational path from inputs. `busy` = (state != IDLE), registered.

Test Plan:
1. Reset check: assert `rst` mid-ASSERT (`rst_req`=1) → `rst_req`, `busy` and `req_count` go to 0 without a clk edge; after release, state IDLE and no pulse until a new request.
2. Soft request: one-cycle `sw_req` at edge 10 → `rst_req` high after edges 11–18 (8 cycles), low after; `busy` back to 0 after edge 18+32+1 (button low); `req_count`=1.
3. Button press: `btn_raw` high from edge 5 and held for 200 cycles → `rst_req` rises after edge 23 for 8 cycles; no second pulse while held; release → IDLE; `req_count`=1.
4. Glitch rejection: `btn_raw` high for 10 cycles then low → no `rst_req`; `req_count`=0; `busy` returns to 0.
5. Priority and drop:
   - `sw_req` pulsed during cycle 5 of a button DEBOUNCE → `rst_req` next cycle.
   - Extra `sw_req` during HOLDOFF → ignored.
   - `req_count`=1.
6. Saturation: issue 260 `sw_req` requests spaced 50 cycles apart → 260 pulses observed; `req_count` stops at 255.
